// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared FSM encodings, sizing and ASCII constants for the UART TX arbiter and its generators
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        SETTLE = 2'd2
    } state_e;

    localparam int NUM_REQ_MAX = 4;
    localparam int PTR_W       = 2;

    localparam logic [7:0] CR    = 8'h0d;
    localparam logic [7:0] LF    = 8'h0a;
    localparam logic [7:0] COMMA = 8'h2c;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, first valid index at or after the pointer, wrapping
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     i_valid,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic             o_any
);

    int idx;

    // walk from the farthest candidate back to the pointer so the nearest valid one wins
    always_comb begin
        o_grant = '0;
        idx     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(i_ptr) + i) % N;
            if (i_valid[idx]) begin
                o_grant      = '0;
                o_grant[idx] = 1'b1;
            end
        end
    end

    assign o_any = |i_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-granular sharing of one uart_tx between NUM_REQ byte streams.
// Optional stall timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int          NUM_REQ     = 2,
    parameter logic [26:0] TIMEOUT_CYC = 27'd27_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]   i_req_last,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_en,
    input  logic                 i_tx_empty,
    output logic                 o_busy,
    output logic                 o_abort
);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         data_q, data_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               end_q, end_d;
    logic [NUM_REQ-1:0] pick;
    logic               any;
    logic [7:0]         sel_data;
    logic [PTR_W-1:0]   sel_idx;
    logic [PTR_W-1:0]   nxt_ptr;
    logic               sel_last;
    logic               accept;
`ifdef UART_ARB_TIMEOUT_EN
    logic [26:0]        stall_q, stall_d;
    logic               abort_q, abort_d;
`endif

    rr_pick #(.N(NUM_REQ)) u_pick (
        .i_valid (i_req_valid),
        .i_ptr   (ptr_q),
        .o_grant (pick),
        .o_any   (any)
    );

    // route the granted requester's byte and index onto the shared channel
    always_comb begin
        sel_data = 8'h00;
        sel_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_q[k]) begin
                sel_data = i_req_data[8*k +: 8];
                sel_idx  = PTR_W'(k);
            end
        end
    end

    assign sel_last    = |(grant_q & i_req_last);
    assign nxt_ptr     = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
    assign o_req_ready = (state_q == SEND && i_tx_empty) ? (grant_q & i_req_valid) : '0;
    assign accept      = |o_req_ready;

    // FSM next state: arbitrate in IDLE, take one byte in SEND, let uart_tx catch up in SETTLE
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        en_d    = 1'b0;
        busy_d  = busy_q;
        end_d   = end_q;
`ifdef UART_ARB_TIMEOUT_EN
        stall_d = stall_q;
        abort_d = 1'b0;
`endif
        if (state_q == IDLE && any) begin
            grant_d = pick;
            busy_d  = 1'b1;
            end_d   = 1'b0;
            state_d = SEND;
`ifdef UART_ARB_TIMEOUT_EN
            stall_d = '0;
`endif
        end
        if (state_q == SEND && accept) begin
            data_d  = sel_data;
            en_d    = 1'b1;
            end_d   = sel_last;
            state_d = SETTLE;
`ifdef UART_ARB_TIMEOUT_EN
            stall_d = '0;
`endif
        end
`ifdef UART_ARB_TIMEOUT_EN
        if (state_q == SEND && !accept) begin
            stall_d = (stall_q == '1) ? stall_q : stall_q + 27'd1;
            if (stall_q >= TIMEOUT_CYC - 27'd1) begin
                abort_d = 1'b1;
                grant_d = '0;
                busy_d  = 1'b0;
                ptr_d   = nxt_ptr;
                state_d = IDLE;
            end
        end
`endif
        if (state_q == SETTLE) begin
            state_d = end_q ? IDLE : SEND;
`ifdef UART_ARB_TIMEOUT_EN
            stall_d = '0;
`endif
            if (end_q) begin
                grant_d = '0;
                busy_d  = 1'b0;
                ptr_d   = nxt_ptr;
            end
        end
    end

    // state and registered outputs; reset drops any message in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            data_q  <= 8'h00;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            end_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            stall_q <= '0;
            abort_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            end_q   <= end_d;
`ifdef UART_ARB_TIMEOUT_EN
            stall_q <= stall_d;
            abort_q <= abort_d;
`endif
        end
    end

    assign o_grant   = grant_q;
    assign o_tx_data = data_q;
    assign o_tx_en   = en_q;
    assign o_busy    = busy_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign o_abort   = abort_q;
`else
    assign o_abort   = 1'b0;
`endif

endmodule
